// File: rtl/shift_seq.sv
//==============================================================================
// Module      : shift_seq
// Description : Multi-cycle 8-bit shifter/rotator, one bit per clock.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module shift_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dir,
    input  logic       rot,
    input  logic       sin,
    input  logic [2:0] amt,
    input  logic [7:0] x,
    output logic [7:0] f,
    output logic       cout,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] f_q, f_d;
    logic       cout_q, cout_d;
    logic [2:0] cnt_q, cnt_d;
    logic       dir_q, dir_d;
    logic       rot_q, rot_d;
    logic       sin_q, sin_d;
    logic       fill;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            f_q     <= 8'h00;
            cout_q  <= 1'b0;
            cnt_q   <= 3'd0;
            dir_q   <= 1'b0;
            rot_q   <= 1'b0;
            sin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            f_q     <= f_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            rot_q   <= rot_d;
            sin_q   <= sin_d;
        end
    end

    always_comb begin
        state_d = state_q;
        f_d     = f_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        rot_d   = rot_q;
        sin_d   = sin_q;
        fill    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    f_d    = x;
                    cout_d = 1'b0;
                    if (amt != 3'd0) begin
                        cnt_d   = amt;
                        dir_d   = dir;
                        rot_d   = rot;
                        sin_d   = sin;
                        state_d = SHIFT;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SHIFT: begin
                // Rotation refills with the bit leaving the opposite end.
                if (dir_q) begin
                    fill   = rot_q ? f_q[0] : sin_q;
                    f_d    = {fill, f_q[7:1]};
                    cout_d = f_q[0];
                end else begin
                    fill   = rot_q ? f_q[7] : sin_q;
                    f_d    = {f_q[6:0], fill};
                    cout_d = f_q[7];
                end
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign f    = f_q;
    assign cout = cout_q;
    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);

endmodule

`default_nettype wire

// File: tb/tb_shift_seq.sv
//==============================================================================
// Module      : tb_shift_seq
// Description : Randomized self-checking bench for shift_seq.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_shift_seq;

    logic       clk = 1'b0;
    logic       rst, start, dir, rot, sin;
    logic [2:0] amt;
    logic [7:0] x;
    logic [7:0] f;
    logic       cout, busy, done;

    int n_checks = 0;
    int n_pass   = 0;

    shift_seq u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .dir   (dir),
        .rot   (rot),
        .sin   (sin),
        .amt   (amt),
        .x     (x),
        .f     (f),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Whole-operation result computed arithmetically from the operand.
    function automatic void ref_model(input logic [7:0] xv, input logic d, input logic r,
                                      input logic s, input int a,
                                      output logic [7:0] fv, output logic c);
        int t, mask;
        t    = int'(xv);
        mask = (1 << a) - 1;
        if (a == 0) begin
            fv = xv;
            c  = 1'b0;
        end else if (!d) begin
            c  = xv[8 - a];
            fv = r ? 8'((t << a) | (t >> (8 - a)))
                   : 8'((t << a) | (s ? mask : 0));
        end else begin
            c  = xv[a - 1];
            fv = r ? 8'((t >> a) | (t << (8 - a)))
                   : 8'((t >> a) | (s ? (mask << (8 - a)) : 0));
        end
    endfunction

    task automatic scramble();
        x   = 8'($urandom);
        dir = 1'($urandom);
        rot = 1'($urandom);
        sin = 1'($urandom);
        amt = 3'($urandom);
    endtask

    task automatic run_op(input logic [7:0] xv, input logic d, input logic r,
                          input logic s, input int a, input bit poke);
        logic [7:0] ef;
        logic       ec;
        int         n, busy_cnt;
        bit         seen;
        ref_model(xv, d, r, s, a, ef, ec);
        @(negedge clk);
        x = xv; dir = d; rot = r; sin = s; amt = 3'(a); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        scramble();
        n = 1; busy_cnt = 0; seen = 1'b0;
        while (n <= 20 && !seen) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) busy_cnt++;
                start = (poke && busy) ? 1'($urandom) : 1'b0;
                scramble();
                @(negedge clk);
                n++;
            end
        end
        check_val("done_seen", 32'(seen), 32'd1);
        check_val("done_latency", 32'(n), 32'(a + 1));
        check_val("busy_cycles", 32'(busy_cnt), 32'(a));
        check_val("result_f", 32'(f), 32'(ef));
        check_val("result_cout", 32'(cout), 32'(ec));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("done_one_cycle", 32'(done), 32'd0);
        check_val("busy_after_done", 32'(busy), 32'd0);
        check_val("f_hold", 32'(f), 32'(ef));
        check_val("cout_hold", 32'(cout), 32'(ec));
        @(negedge clk);
        check_val("start_in_done_ignored", 32'({busy, done}), 32'd0);
    endtask

    initial begin
        bit done_seen;
        rst = 1'b1; start = 1'b1; dir = 1'b0; rot = 1'b0; sin = 1'b0; amt = 3'd3; x = 8'h5A;
        repeat (3) @(negedge clk);
        check_val("rst_f", 32'(f), 32'h00);
        check_val("rst_cout", 32'(cout), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check_val("idle_hold_f", 32'(f), 32'h00);

        run_op(8'h01, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        run_op(8'h81, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        run_op(8'h81, 1'b0, 1'b1, 1'b0, 3, 1'b1);
        run_op(8'h00, 1'b1, 1'b0, 1'b1, 7, 1'b1);
        run_op(8'hA5, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        run_op(8'h3C, 1'b1, 1'b1, 1'b0, 7, 1'b0);

        // Reset aborting an operation in its third SHIFT cycle.
        @(negedge clk);
        x = 8'hFF; dir = 1'b0; rot = 1'b0; sin = 1'b0; amt = 3'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("abort_busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("abort_f", 32'(f), 32'h00);
        check_val("abort_cout", 32'(cout), 32'd0);
        check_val("abort_busy", 32'(busy), 32'd0);
        done_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) done_seen = 1'b1;
            @(negedge clk);
        end
        check_val("abort_no_done", 32'(done_seen), 32'd0);

        for (int i = 0; i < 40; i++) begin
            run_op(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 7)), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/shift_seq.md
SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 dir  input  1  0 = shift left (toward bit 7), 1 = shift right (toward bit 0); captured with start.
REQ-006 rot  input  1  1 = rotate (fill with the bit shifted out), 0 = logical shift with fill from sin; captured with start.
REQ-007 sin  input  1  serial fill bit when rot=0; captured with start.
REQ-008 amt  input  3  number of single-bit shift steps, 0..7; captured with start.
REQ-009 x  input  8  operand, bit 0 LSB; captured with start.
REQ-010 f  output  8  result register; holds its value outside SHIFT.
REQ-011 cout  output  1  registered copy of the last bit shifted out.
REQ-012 busy  output  1  high while state=SHIFT.
REQ-013 done  output  1  high for exactly one cycle while state=DONE.

Function
REQ-014 The block SHALL implement states IDLE, SHIFT and DONE; busy and done SHALL be decoded from state only.
REQ-015 IDLE, start=1, amt>0 -> at that edge: f<=x, cout<=0, cnt<=amt, dir/rot/sin latched; next state SHIFT.
REQ-016 IDLE, start=1, amt=0 -> at that edge: f<=x, cout<=0; next state DONE.
REQ-017 IDLE, start=0 -> f, cout and state SHALL hold.
REQ-018 In SHIFT, left step: f<={f[6:0],fill}, cout<=f[7]; fill = rot ? f[7] : sin_latched.
REQ-019 In SHIFT, right step: f<={fill,f[7:1]}, cout<=f[0]; fill = rot ? f[0] : sin_latched.
REQ-020 SHIFT SHALL do exactly one step per clock and decrement cnt; the step with cnt=1 SHALL move the state to DONE.
REQ-021 DONE SHALL last exactly one cycle, then return to IDLE with f and cout unchanged.
REQ-022 Latency: start sampled at edge k -> final step at edge k+amt -> done high in the cycle after edge k+amt (after edge k when amt=0).
REQ-023 start while busy or done is high SHALL be ignored and SHALL NOT be queued.
REQ-024 x, dir, rot, sin and amt changes after the start edge SHALL NOT affect the operation in progress.
REQ-025 A start in the cycle done is high SHALL be ignored; a new operation requires start in IDLE.

Reset
REQ-026 rst=1 at an edge SHALL force state=IDLE, f=8'h00, cout=0, busy=0, done=0, cnt=0, and clear latched dir/rot/sin.
REQ-027 Reset SHALL take priority over start and over any step in SHIFT or DONE; an aborted operation SHALL NOT assert done.

Verification
REQ-028 rst, then x=8'h01, dir=0, rot=0, sin=0, amt=1, start -> f=8'h02, cout=0; done high in the cycle after the edge following the start edge.
REQ-029 x=8'h81, dir=0, rot=0, sin=0, amt=1 -> f=8'h02, cout=1.
REQ-030 x=8'h81, dir=0, rot=1, amt=3 -> busy high for 3 cycles; f=8'h0C, cout=0.
REQ-031 x=8'h00, dir=1, rot=0, sin=1, amt=7 -> f=8'hFE, cout=0; done one cycle only.
REQ-032 x=8'hA5, amt=0 -> f=8'hA5, cout=0, busy never high, done after one edge.
REQ-033 x=8'hFF, left, amt=5; pulse start again mid-SHIFT (ignored); rst at the 3rd SHIFT cycle -> f=8'h00, cout=0, IDLE, no done pulse.
